alto_result_latch: RTL
======================

Name: alto_result_latch

Overview:
- Sequential back end of the Alto ALU datapath.
- Latches the ALU result and carry into L, T and ALUC0, and performs shifter operations on L: LSH1, RSH1 and LCY8, plus MAGIC and Nova-style DNS shifts.
- Holds the emulator carry flag.
- Sits between the ALU output and the processor bus. The shifter result feeds the bus, R/S register writes and shifter-condition branches.

Parameters:
- L_RESET, 16'h0000, L value after reset.
- T_RESET, 16'h0000, T value after reset.

Ports:
- clk_i  in  1  system clock, all state updates on rising edge
- rst_i  in  1  reset; asynchronous and active-high
- stall_i  in  1  1 = freeze all registers this cycle (memory wait / task hold)
- aluf_i  in  4  ALU function of the current microinstruction (ALTO_ALUF_* encoding)
- alu_result_i  in  16  ALU output
- alu_carry_i  in  1  ALU carry out
- bus_i  in  16  processor bus
- load_l_i  in  1  L← this cycle
- load_t_i  in  1  T← this cycle
- shift_op_i  in  2  00 NONE, 01 LSH1, 10 RSH1, 11 LCY8
- magic_i  in  1  MAGIC modifier on LSH1/RSH1
- dns_i  in  1  DNS: Nova shift through emulator carry, commits carry
- cy_op_i  in  2  Nova carry op for DNS: 00 keep, 01 zero, 10 one, 11 complement
- l_o  out  16  L register
- t_o  out  16  T register
- aluc0_o  out  1  latched ALU carry
- shifter_o  out  16  shifter output, combinational from L, T, carry
- shifter_zero_o  out  1  shifter_o == 0
- shifter_neg_o  out  1  shifter_o[15]
- emu_carry_o  out  1  emulator carry flag

Behaviour:
- Reset, asynchronous: l_o=L_RESET, t_o=T_RESET, aluc0_o=0, emu_carry_o=0. Derived outputs follow. Reset mid-stall or mid-DNS discards the pending update.
- All register updates occur on the rising edge with stall_i=0. With stall_i=1 every register holds, including emu_carry.
- load_l_i: L←alu_result_i and ALUC0←alu_carry_i on the same edge. ALUC0 changes only with L loads.
- load_t_i: T source is alu_result_i when aluf_i ∈ {BUS, BUS_OR_T, BUS_PLUS_1, BUS_MINUS_1, BUS_PLUS_T_PLUS_1, BUS_PLUS_SKIP, BUS_AND_T_ALT}; otherwise bus_i.
- Simultaneous load_l_i/load_t_i are independent. The shifter uses pre-edge L and T.
- Shifter (combinational on registered L):
  - NONE: L.
  - LSH1: {L[14:0], fill}. Fill is T[15] if magic, else 0.
  - RSH1: {fill, L[15:1]}. Fill is T[0] if magic, else 0.
  - LCY8: {L[7:0], L[15:8]}. magic/dns ignored.
- DNS (dns_i=1, overrides magic):
  - base = cy_op applied to emu_carry.
  - cpre = base ^ aluc0_o.
  - LSH1: out = {L[14:0], cpre}, new carry = L[15].
  - RSH1: out = {cpre, L[15:1]}, new carry = L[0].
  - NONE/LCY8: out as normal, new carry = cpre.
  - emu_carry←new carry on the edge, not stalled.
- Latency: L/T/ALUC0/carry visible 1 cycle after the load edge. Shifter outputs are valid in the same cycle as L.

Optional Feature:
- Macro: ALTO_DNS_EN.
- Defined: DNS and cy_op behave as above; emu_carry_o is a register.
- Undefined: dns_i and cy_op_i are ignored, emu_carry_o is tied 0, and the shifter behaves as if dns_i=0.

Decomposition:
- alto_definitions.v: ALTO_ALUF_* (existing), ALTO_SHIFT_NONE/LSH1/RSH1/LCY8, ALTO_CY_KEEP/ZERO/ONE/CPL, and the T-from-ALU predicate macro.
- One sub-module: alto_shifter. It is combinational (L, T, shift_op, magic, dns, cpre → out, carry_next). The top level holds the registers.

Test Plan:
- Reset asserted mid-cycle with L=16'h1234 loaded → l_o=0, t_o=0, aluc0_o=0, emu_carry_o=0 immediately, without waiting for a clock edge.
- load_l/load_t with aluf=BUS_PLUS_1, bus=16'hFFFF, result=16'h0000, carry=1 → L=0, T=0, ALUC0=1, shifter_zero_o=1. Repeat with aluf=BUS_PLUS_T → T=16'hFFFF.
- L=16'h8001, T=16'h8000: LSH1 magic → 16'h0003; RSH1 magic → 16'h4000; LCY8 → 16'h0180.
- DNS: L=16'h8001, emu_carry=0, aluc0=1, cy_op=keep, LSH1 → shifter_o=16'h0003, emu_carry→1. Then RSH1, cy_op=zero, aluc0=1 → shifter_o=16'hC000, emu_carry→1.
- stall_i=1 with load_l, load_t and dns all asserted → no register changes. Deassert stall → updates on the next edge.
- Build without ALTO_DNS_EN: dns_i=1, LSH1, L=16'h8000 → shifter_o=16'h0000, emu_carry_o stays 0.

Source files
------------

// File: rtl/alto_result_latch_pkg.sv
// Shared encodings for the Alto result latch: ALU functions, shifter ops and Nova carry ops.
// Optional DNS support is selected with the ALTO_DNS_EN macro in alto_result_latch.sv.
package alto_result_latch_pkg;

  localparam logic [3:0] ALTO_ALUF_BUS                 = 4'd0;
  localparam logic [3:0] ALTO_ALUF_T                   = 4'd1;
  localparam logic [3:0] ALTO_ALUF_BUS_OR_T            = 4'd2;
  localparam logic [3:0] ALTO_ALUF_BUS_AND_T           = 4'd3;
  localparam logic [3:0] ALTO_ALUF_BUS_XOR_T           = 4'd4;
  localparam logic [3:0] ALTO_ALUF_BUS_PLUS_1          = 4'd5;
  localparam logic [3:0] ALTO_ALUF_BUS_MINUS_1         = 4'd6;
  localparam logic [3:0] ALTO_ALUF_BUS_PLUS_T          = 4'd7;
  localparam logic [3:0] ALTO_ALUF_BUS_MINUS_T         = 4'd8;
  localparam logic [3:0] ALTO_ALUF_BUS_MINUS_T_MINUS_1 = 4'd9;
  localparam logic [3:0] ALTO_ALUF_BUS_PLUS_T_PLUS_1   = 4'd10;
  localparam logic [3:0] ALTO_ALUF_BUS_PLUS_SKIP       = 4'd11;
  localparam logic [3:0] ALTO_ALUF_BUS_AND_T_ALT       = 4'd12;
  localparam logic [3:0] ALTO_ALUF_BUS_AND_NOT_T       = 4'd13;

  localparam logic [1:0] ALTO_SHIFT_NONE = 2'b00;
  localparam logic [1:0] ALTO_SHIFT_LSH1 = 2'b01;
  localparam logic [1:0] ALTO_SHIFT_RSH1 = 2'b10;
  localparam logic [1:0] ALTO_SHIFT_LCY8 = 2'b11;

  localparam logic [1:0] ALTO_CY_KEEP = 2'b00;
  localparam logic [1:0] ALTO_CY_ZERO = 2'b01;
  localparam logic [1:0] ALTO_CY_ONE  = 2'b10;
  localparam logic [1:0] ALTO_CY_CPL  = 2'b11;

  // ALU functions whose T load takes the ALU output instead of the bus.
  function automatic logic alto_t_from_alu(input logic [3:0] aluf);
    return aluf inside {ALTO_ALUF_BUS, ALTO_ALUF_BUS_OR_T, ALTO_ALUF_BUS_PLUS_1,
                        ALTO_ALUF_BUS_MINUS_1, ALTO_ALUF_BUS_PLUS_T_PLUS_1,
                        ALTO_ALUF_BUS_PLUS_SKIP, ALTO_ALUF_BUS_AND_T_ALT};
  endfunction

  function automatic logic alto_cy_base(input logic [1:0] cy_op, input logic carry);
    logic base;
    case (cy_op)
      ALTO_CY_ZERO: base = 1'b0;
      ALTO_CY_ONE:  base = 1'b1;
      ALTO_CY_CPL:  base = ~carry;
      default:      base = carry;
    endcase
    return base;
  endfunction

endpackage

// File: rtl/alto_result_latch_shifter.sv
// Combinational L shifter: LSH1/RSH1/LCY8 with MAGIC fill from T, or DNS fill from the
// pre-shift Nova carry; also produces the carry that a DNS shift would commit.
module alto_result_latch_shifter
  import alto_result_latch_pkg::*;
(
  input  logic [15:0] l_i,
  input  logic [15:0] t_i,
  input  logic [1:0]  shift_op_i,
  input  logic        magic_i,
  input  logic        dns_i,
  input  logic        cpre_i,
  output logic [15:0] shift_o,
  output logic        carry_next_o
);

  logic lsh_fill;
  logic rsh_fill;

  // DNS takes priority over MAGIC for the fill bit.
  assign lsh_fill = dns_i ? cpre_i : (magic_i & t_i[15]);
  assign rsh_fill = dns_i ? cpre_i : (magic_i & t_i[0]);

  // NOTE: every output gets a default first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    shift_o      = l_i;
    carry_next_o = cpre_i;
    case (shift_op_i)
      ALTO_SHIFT_LSH1: begin
        shift_o      = {l_i[14:0], lsh_fill};
        carry_next_o = l_i[15];
      end
      ALTO_SHIFT_RSH1: begin
        shift_o      = {rsh_fill, l_i[15:1]};
        carry_next_o = l_i[0];
      end
      ALTO_SHIFT_LCY8: shift_o = {l_i[7:0], l_i[15:8]};
      default: ;
    endcase
  end

endmodule

// File: rtl/alto_result_latch.sv
// Alto ALU back end: L/T/ALUC0 latches, shifter on L, and (with ALTO_DNS_EN defined) the
// emulator carry updated by Nova-style DNS shifts. Without ALTO_DNS_EN the carry reads 0.
module alto_result_latch
  import alto_result_latch_pkg::*;
#(
  parameter logic [15:0] L_RESET = 16'h0000,
  parameter logic [15:0] T_RESET = 16'h0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic [3:0]  aluf_i,
  input  logic [15:0] alu_result_i,
  input  logic        alu_carry_i,
  input  logic [15:0] bus_i,
  input  logic        load_l_i,
  input  logic        load_t_i,
  input  logic [1:0]  shift_op_i,
  input  logic        magic_i,
  input  logic        dns_i,
  input  logic [1:0]  cy_op_i,
  output logic [15:0] l_o,
  output logic [15:0] t_o,
  output logic        aluc0_o,
  output logic [15:0] shifter_o,
  output logic        shifter_zero_o,
  output logic        shifter_neg_o,
  output logic        emu_carry_o
);

  logic [15:0] l_q, l_d;
  logic [15:0] t_q, t_d;
  logic        aluc0_q, aluc0_d;
  logic        dns_eff;
  logic        cpre;
  logic        shift_carry_next;

`ifdef ALTO_DNS_EN
  logic emu_carry_q, emu_carry_d;

  assign dns_eff = dns_i;
  assign cpre    = alto_cy_base(cy_op_i, emu_carry_q) ^ aluc0_q;

  always_comb begin
    emu_carry_d = emu_carry_q;
    if (!stall_i && dns_i) emu_carry_d = shift_carry_next;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) emu_carry_q <= 1'b0;
    else       emu_carry_q <= emu_carry_d;
  end

  assign emu_carry_o = emu_carry_q;
`else
  logic unused_dns;

  assign dns_eff     = 1'b0;
  assign cpre        = 1'b0;
  assign emu_carry_o = 1'b0;
  assign unused_dns  = ^{dns_i, cy_op_i, shift_carry_next};
`endif

  always_comb begin
    l_d     = l_q;
    t_d     = t_q;
    aluc0_d = aluc0_q;
    if (!stall_i) begin
      if (load_l_i) begin
        l_d     = alu_result_i;
        aluc0_d = alu_carry_i;
      end
      if (load_t_i) t_d = alto_t_from_alu(aluf_i) ? alu_result_i : bus_i;
    end
  end

  // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      l_q     <= L_RESET;
      t_q     <= T_RESET;
      aluc0_q <= 1'b0;
    end else begin
      l_q     <= l_d;
      t_q     <= t_d;
      aluc0_q <= aluc0_d;
    end
  end

  alto_result_latch_shifter u_shifter (
    .l_i          (l_q),
    .t_i          (t_q),
    .shift_op_i   (shift_op_i),
    .magic_i      (magic_i),
    .dns_i        (dns_eff),
    .cpre_i       (cpre),
    .shift_o      (shifter_o),
    .carry_next_o (shift_carry_next)
  );

  assign l_o            = l_q;
  assign t_o            = t_q;
  assign aluc0_o        = aluc0_q;
  assign shifter_zero_o = (shifter_o == 16'h0000);
  assign shifter_neg_o  = shifter_o[15];

endmodule
